// File: rtl/png_unfilter.sv
// png_unfilter: rebuilds raw pixel bytes from a PNG filtered scanline stream.
// Each row is one filter-type byte followed by cfg_w_i data bytes. The
// None/Sub/Up/Average/Paeth filters are undone using a register-array
// prior-row buffer plus short left (a) and upper-left (c) history registers.
module png_unfilter #(
  parameter int SIZE      = 512,
  parameter int SIZE_WD   = $clog2(SIZE),
  parameter int SIZE_W_WD = $clog2(SIZE + 1),
  parameter int SIZE_H_WD = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [SIZE_W_WD-1:0] cfg_w_i,
  input  logic [SIZE_H_WD-1:0] cfg_h_i,
  input  logic [2:0]           cfg_bpp_i,
  input  logic                 start_i,
  input  logic                 dat_val_i,
  input  logic [7:0]           dat_i,
  output logic                 val_o,
  output logic [7:0]           dat_o,
  output logic                 row_done_o,
  output logic                 done_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {IDLE, TYPE, DATA} state_t;

  state_t               state_reg;
  logic [SIZE_W_WD-1:0] cfg_w_reg;
  logic [SIZE_H_WD-1:0] cfg_h_reg;
  logic [1:0]           bpp_m1_reg;     // bytes-per-pixel minus one (0..3)
  logic [2:0]           ftype_reg;      // illegal types already folded to None
  logic [SIZE_WD-1:0]   col_reg;
  logic [SIZE_H_WD-1:0] row_cnt_reg;
  logic                 first_row_reg;
  logic [3:0][7:0]      a_hist_reg;     // [0] = most recent reconstructed byte
  logic [3:0][7:0]      c_hist_reg;     // [0] = most recent prior-row byte

  logic [7:0] line_buf [SIZE];

  logic [2:0]        bpp_val;
  logic              col_ge_bpp;
  logic              last_col;
  logic [7:0]        a_val, b_val, c_val, pred, recon;
  logic [8:0]        avg_sum;
  logic signed [9:0] p_val, pa, pb, pc;

  function automatic logic signed [9:0] abs10(input logic signed [9:0] v);
    return (v < 0) ? -v : v;
  endfunction

  // Predictor selection and reconstruction of the byte currently on dat_i
  always_comb begin
    bpp_val    = {1'b0, bpp_m1_reg} + 3'd1;
    col_ge_bpp = (col_reg >= SIZE_WD'(bpp_val));
    last_col   = (SIZE_W_WD'(col_reg) == cfg_w_reg - SIZE_W_WD'(1));
    a_val      = col_ge_bpp ? a_hist_reg[bpp_m1_reg] : 8'd0;
    b_val      = first_row_reg ? 8'd0 : line_buf[col_reg];
    c_val      = (col_ge_bpp && !first_row_reg) ? c_hist_reg[bpp_m1_reg] : 8'd0;
    avg_sum    = {1'b0, a_val} + {1'b0, b_val};
    p_val      = $signed({2'b00, a_val}) + $signed({2'b00, b_val}) - $signed({2'b00, c_val});
    pa         = abs10(p_val - $signed({2'b00, a_val}));
    pb         = abs10(p_val - $signed({2'b00, b_val}));
    pc         = abs10(p_val - $signed({2'b00, c_val}));
    pred       = 8'd0;
    case (ftype_reg)
      3'd1:    pred = a_val;
      3'd2:    pred = b_val;
      3'd3:    pred = avg_sum[8:1];
      3'd4:    pred = (pa <= pb && pa <= pc) ? a_val : ((pb <= pc) ? b_val : c_val);
      default: pred = 8'd0;
    endcase
    recon = dat_i + pred;
  end

  // Prior-row buffer: the old value is read combinationally, the new one lands at the edge
  always_ff @(posedge clk) begin
    if (state_reg == DATA && dat_val_i && !start_i)
      line_buf[col_reg] <= recon;
  end

  // Control FSM, history shift registers and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      cfg_w_reg     <= '0;
      cfg_h_reg     <= '0;
      bpp_m1_reg    <= '0;
      ftype_reg     <= '0;
      col_reg       <= '0;
      row_cnt_reg   <= '0;
      first_row_reg <= 1'b1;
      a_hist_reg    <= '0;
      c_hist_reg    <= '0;
      val_o         <= 1'b0;
      dat_o         <= 8'd0;
      row_done_o    <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      val_o      <= 1'b0;
      row_done_o <= 1'b0;
      done_o     <= 1'b0;
      if (start_i) begin
        cfg_w_reg     <= cfg_w_i;
        cfg_h_reg     <= cfg_h_i;
        bpp_m1_reg    <= (cfg_bpp_i == 3'd0) ? 2'd0 :
                         (cfg_bpp_i > 3'd4)  ? 2'd3 : 2'(cfg_bpp_i - 3'd1);
        row_cnt_reg   <= '0;
        first_row_reg <= 1'b1;
        err_o         <= 1'b0;
        state_reg     <= TYPE;
      end else begin
        case (state_reg)
          TYPE: begin
            if (dat_val_i) begin
              if (dat_i > 8'd4) begin
                ftype_reg <= 3'd0;
                err_o     <= 1'b1;
              end else begin
                ftype_reg <= dat_i[2:0];
              end
              col_reg    <= '0;
              a_hist_reg <= '0;
              c_hist_reg <= '0;
              state_reg  <= DATA;
            end
          end
          DATA: begin
            if (dat_val_i) begin
              val_o      <= 1'b1;
              dat_o      <= recon;
              a_hist_reg <= {a_hist_reg[2:0], recon};
              c_hist_reg <= {c_hist_reg[2:0], b_val};
              if (last_col) begin
                row_done_o    <= 1'b1;
                first_row_reg <= 1'b0;
                row_cnt_reg   <= row_cnt_reg + 1'b1;
                if (row_cnt_reg == cfg_h_reg - 1'b1) begin
                  done_o    <= 1'b1;
                  state_reg <= IDLE;
                end else begin
                  state_reg <= TYPE;
                end
              end else begin
                col_reg <= col_reg + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_png_unfilter.sv
// Directed bench for png_unfilter: stimulus pushes expected bytes into a
// scoreboard queue, a monitor pops and compares whenever val_o is seen.
module tb_png_unfilter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [9:0]  cfg_w_i;
  logic [15:0] cfg_h_i;
  logic [2:0]  cfg_bpp_i;
  logic        start_i;
  logic        dat_val_i;
  logic [7:0]  dat_i;
  logic        val_o;
  logic [7:0]  dat_o;
  logic        row_done_o;
  logic        done_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];   // {done, row_done, byte}

  png_unfilter dut (
    .clk(clk), .rstn(rstn), .cfg_w_i(cfg_w_i), .cfg_h_i(cfg_h_i),
    .cfg_bpp_i(cfg_bpp_i), .start_i(start_i), .dat_val_i(dat_val_i),
    .dat_i(dat_i), .val_o(val_o), .dat_o(dat_o), .row_done_o(row_done_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: compare each presented output against the head of the scoreboard
  always @(negedge clk) begin
    if (rstn) begin
      if (val_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got dat=%0d with empty scoreboard", dat_o);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          check("dat_o", dat_o, e[7:0]);
          check("row_done_o", row_done_o, e[8]);
          check("done_o", done_o, e[9]);
          $display("out dat=%0d row_done=%0d done=%0d", dat_o, row_done_o, done_o);
        end
      end else if (row_done_o || done_o) begin
        check("pulse_without_val", 1, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_img(input int w, input int h, input int bpp);
    cfg_w_i   = 10'(w);
    cfg_h_i   = 16'(h);
    cfg_bpp_i = 3'(bpp);
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
    cfg_w_i   = 10'd1;      // garbage after start must not matter
    cfg_h_i   = 16'd9;
    cfg_bpp_i = 3'd2;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    repeat (gap) tick();
    dat_val_i = 1'b1;
    dat_i     = d;
    tick();
    dat_val_i = 1'b0;
    dat_i     = 8'h5A;
  endtask

  // One row: type byte, then n data bytes with expected reconstruction
  task automatic run_row(input logic [7:0] ft, input int n,
                         input logic [7:0] din [8], input logic [7:0] dexp [8],
                         input bit last_row, input int max_gap);
    send_byte(ft, 0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({last_row && (i == n - 1), i == n - 1, dexp[i]});
      send_byte(din[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
    tick();
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    rstn = 1'b0; cfg_w_i = '0; cfg_h_i = '0; cfg_bpp_i = '0;
    start_i = 1'b0; dat_val_i = 1'b0; dat_i = '0;
    repeat (3) tick();
    check("reset_val_o", val_o, 0);
    check("reset_dat_o", dat_o, 0);
    check("reset_err_o", err_o, 0);
    rstn = 1'b1;
    tick();

    // 1: None row, then bytes in IDLE must be ignored
    start_img(4, 1, 1);
    run_row(8'd0, 4, '{10,20,30,40,0,0,0,0}, '{10,20,30,40,0,0,0,0}, 1, 0);
    drain();
    send_byte(8'd0, 0);
    send_byte(8'd7, 0);
    drain();
    check("idle_err_o", err_o, 0);

    // 2: Sub with wrap
    start_img(4, 1, 1);
    run_row(8'd1, 4, '{10,10,10,250,0,0,0,0}, '{10,20,30,24,0,0,0,0}, 1, 0);
    drain();

    // 3: None then Up
    start_img(4, 2, 1);
    run_row(8'd0, 4, '{1,2,3,4,0,0,0,0}, '{1,2,3,4,0,0,0,0}, 0, 0);
    run_row(8'd2, 4, '{1,1,1,1,0,0,0,0}, '{2,3,4,5,0,0,0,0}, 1, 0);
    drain();

    // 4: None, Average, Paeth (pb wins)
    start_img(2, 3, 1);
    run_row(8'd0, 2, '{10,20,0,0,0,0,0,0}, '{10,20,0,0,0,0,0,0}, 0, 0);
    run_row(8'd3, 2, '{5,5,0,0,0,0,0,0},   '{10,20,0,0,0,0,0,0}, 0, 0);
    run_row(8'd4, 2, '{0,0,0,0,0,0,0,0},   '{10,20,0,0,0,0,0,0}, 1, 0);
    drain();

    // 5: bpp=3 Sub, without and with random gaps
    start_img(6, 1, 3);
    run_row(8'd1, 6, '{1,2,3,1,1,1,0,0}, '{1,2,3,2,3,4,0,0}, 1, 0);
    drain();
    start_img(6, 1, 3);
    run_row(8'd1, 6, '{1,2,3,1,1,1,0,0}, '{1,2,3,2,3,4,0,0}, 1, 3);
    drain();

    // bpp 7 clamps to 4; width below bpp means no left neighbour
    start_img(3, 1, 7);
    run_row(8'd1, 3, '{1,1,1,0,0,0,0,0}, '{1,1,1,0,0,0,0,0}, 1, 0);
    drain();

    // 6: illegal type decodes as None and sets sticky err_o
    start_img(3, 1, 1);
    run_row(8'd7, 3, '{5,6,7,0,0,0,0,0}, '{5,6,7,0,0,0,0,0}, 1, 0);
    drain();
    check("err_sticky", err_o, 1);
    start_img(3, 1, 1);
    check("err_cleared_on_start", err_o, 0);

    // restart mid-row, then reset mid-row
    send_byte(8'd0, 0);
    exp_q.push_back({1'b0, 1'b0, 8'd9});
    send_byte(8'd9, 0);
    start_img(4, 1, 1);
    send_byte(8'd0, 0);
    exp_q.push_back({1'b0, 1'b0, 8'd8});
    send_byte(8'd8, 0);
    drain();
    rstn = 1'b0;
    #2;
    check("rst_val_o", val_o, 0);
    check("rst_dat_o", dat_o, 0);
    check("rst_row_done_o", row_done_o, 0);
    check("rst_done_o", done_o, 0);
    check("rst_err_o", err_o, 0);
    tick();
    rstn = 1'b1;
    tick();
    start_img(2, 1, 1);
    run_row(8'd0, 2, '{3,4,0,0,0,0,0,0}, '{3,4,0,0,0,0,0,0}, 1, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
